// File: rtl/encoder_4to2_buf.sv
// Registered 4-to-2 priority encoder with a 2-entry output buffer.
// Optional one-hot checking (out_multi, err_cnt) via ENC_ONEHOT_CHECK_EN.
module encoder_4to2_buf #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           d,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 y0,
  output logic                 y1,
  output logic                 out_zero,
  output logic                 out_multi,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] head;
  logic [3:0] tail;
  logic [3:0] head_nxt;
  logic [3:0] tail_nxt;
  logic [3:0] enc;
  logic [1:0] code;
  logic       zero;
  logic       multi;
  logic       push;
  logic       pop;

  // Priority encode of the incoming word; entry is {code, zero, multi}.
  always_comb begin
    code = 2'b00;
    unique case (1'b1)
      d[3]:                   code = 2'b11;
      d[2] && !d[3]:          code = 2'b10;
      d[1] && d[3:2] == 2'b0: code = 2'b01;
      d[0] && d[3:1] == 3'b0: code = 2'b00;
      default:                code = 2'b00;
    endcase
    zero = (d == 4'b0000);
`ifdef ENC_ONEHOT_CHECK_EN
    multi = ((d & (d - 4'd1)) != 4'b0000);
`else
    multi = 1'b0;
`endif
    enc = {code, zero, multi};
  end

  // Occupancy FSM: handshakes and next head/tail contents.
  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    tail_nxt  = tail;
    in_ready  = (state != TWO);
    out_valid = (state != EMPTY);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    unique case (state)
      EMPTY: begin
        if (push) begin
          head_nxt  = enc;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_nxt = enc;
        end else if (push) begin
          tail_nxt  = enc;
          state_nxt = TWO;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_nxt  = tail;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // State and buffer registers; head keeps its value when drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      head  <= 4'b0000;
      tail  <= 4'b0000;
    end else begin
      state <= state_nxt;
      head  <= head_nxt;
      tail  <= tail_nxt;
    end
  end

  assign {y0, y1, out_zero, out_multi} = head;

`ifdef ENC_ONEHOT_CHECK_EN
  // Saturating count of accepted zero or multi-hot words.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (push && (zero || multi) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_encoder_4to2_buf.sv
// Directed bench for encoder_4to2_buf.
// Expectations follow ENC_ONEHOT_CHECK_EN the same way the build does.
module tb_encoder_4to2_buf;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   d;
  logic         out_valid;
  logic         out_ready;
  logic         y0;
  logic         y1;
  logic         out_zero;
  logic         out_multi;
  logic [W-1:0] err_cnt;

  int checks   = 0;
  int failures = 0;
  int err_exp  = 0;

  encoder_4to2_buf #(.ERR_CNT_W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .d(d),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0(y0), .y1(y1),
    .out_zero(out_zero), .out_multi(out_multi),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag,
                          input logic [1:0] c,
                          input logic z,
                          input logic m);
    chk({tag, "_code"}, {6'b0, y0, y1}, {6'b0, c});
    chk({tag, "_zero"}, {7'b0, out_zero}, {7'b0, z});
    chk({tag, "_multi"}, {7'b0, out_multi}, {7'b0, m});
  endtask

  task automatic chk_err(input string tag);
    chk(tag, {{(8-W){1'b0}}, err_cnt}, 8'(err_exp));
  endtask

  logic [3:0] bad_d [7] = '{4'b0000, 4'b0110, 4'b1111,
                            4'b0011, 4'b0000, 4'b1100, 4'b0101};
  logic [1:0] bad_c [7] = '{2'b00, 2'b10, 2'b11,
                            2'b01, 2'b00, 2'b11, 2'b10};
  logic       bad_z [7] = '{1'b1, 1'b0, 1'b0,
                            1'b0, 1'b1, 1'b0, 1'b0};
  logic [3:0] one_d [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [1:0] one_c [4] = '{2'b00, 2'b01, 2'b10, 2'b11};

  initial begin
    logic m_on;
`ifdef ENC_ONEHOT_CHECK_EN
    m_on = 1'b1;
`else
    m_on = 1'b0;
`endif
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    d = 4'b0000;
    step();
    step();
    chk("rst_ovalid", {7'b0, out_valid}, 8'd0);
    chk("rst_iready", {7'b0, in_ready}, 8'd1);
    chk_head("rst", 2'b00, 1'b0, 1'b0);
    chk_err("rst_err");
    rst = 1'b0;

    // single one-hot pushes at full throughput
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = one_d[i];
      step();
      chk($sformatf("oh%0d_ovalid", i), {7'b0, out_valid}, 8'd1);
      chk_head($sformatf("oh%0d", i), one_c[i], 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    step();
    chk("drain_ovalid", {7'b0, out_valid}, 8'd0);
    chk_head("drain_hold", 2'b11, 1'b0, 1'b0);
    chk_err("oh_err");

    // backpressure to full
    out_ready = 1'b0;
    in_valid = 1'b1;
    d = 4'b0100;
    step();
    chk("bp1_iready", {7'b0, in_ready}, 8'd1);
    d = 4'b1000;
    step();
    chk("bp2_iready", {7'b0, in_ready}, 8'd0);
    chk_head("bp2", 2'b10, 1'b0, 1'b0);
    d = 4'b0001;
    step();
    chk("bp3_iready", {7'b0, in_ready}, 8'd0);
    chk_head("bp3", 2'b10, 1'b0, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk_head("bp_pop1", 2'b11, 1'b0, 1'b0);
    chk("bp_pop1_iready", {7'b0, in_ready}, 8'd1);
    chk("bp_pop1_ovalid", {7'b0, out_valid}, 8'd1);
    step();
    chk("bp_pop2_ovalid", {7'b0, out_valid}, 8'd0);
    chk("bp_pop2_iready", {7'b0, in_ready}, 8'd1);

    // push+pop while holding one entry
    out_ready = 1'b0;
    in_valid = 1'b1;
    d = 4'b1000;
    step();
    chk_head("pp_fill", 2'b11, 1'b0, 1'b0);
    d = 4'b0010;
    out_ready = 1'b1;
    step();
    chk_head("pp", 2'b01, 1'b0, 1'b0);
    chk("pp_iready", {7'b0, in_ready}, 8'd1);
    in_valid = 1'b0;
    step();
    chk("pp_empty", {7'b0, out_valid}, 8'd0);

    // zero and multi-hot words, counter saturation
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      d = bad_d[i];
      step();
      if (m_on && err_exp < 3) err_exp++;
      chk_head($sformatf("bad%0d", i), bad_c[i], bad_z[i],
               m_on & ~bad_z[i]);
      chk_err($sformatf("bad%0d_err", i));
    end
    in_valid = 1'b0;
    step();
    chk_err("bad_pop_err");

    // reset while full with push and pop requested
    out_ready = 1'b0;
    in_valid = 1'b1;
    d = 4'b0001;
    step();
    d = 4'b0010;
    step();
    chk("full_iready", {7'b0, in_ready}, 8'd0);
    rst = 1'b1;
    d = 4'b1111;
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    err_exp = 0;
    chk("mrst_ovalid", {7'b0, out_valid}, 8'd0);
    chk("mrst_iready", {7'b0, in_ready}, 8'd1);
    chk_head("mrst", 2'b00, 1'b0, 1'b0);
    chk_err("mrst_err");
    step();
    chk("mrst2_ovalid", {7'b0, out_valid}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder_4to2_buf.md
Name: encoder_4to2_buf

Overview:
Registered 4-to-2 priority encoder; inverse of the team's 2-to-4 decoder. It sits where one-hot select lines have to be folded back into a 2-bit code.
- Accepts a 4-bit word over a valid/ready handshake.
- Encodes the word and queues the result in a 2-entry output buffer.
- Flags zero and multi-hot inputs on the output side.

Parameters:
ERR_CNT_W, 8, width of the saturating error counter err_cnt.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; synchronous, active-high
in_valid  input  1  upstream word present
in_ready  output  1  block can accept a word this cycle
d  input  4  input word; bit i is line di (d0..d3)
out_valid  output  1  encoded entry at head of buffer
out_ready  input  1  downstream takes head entry this cycle
y0  output  1  code MSB (same bit weighting as the decoder's y0)
y1  output  1  code LSB
out_zero  output  1  head entry came from d == 4'b0000
out_multi  output  1  head entry came from a word with more than one bit set
err_cnt  output  ERR_CNT_W  count of accepted zero/multi-hot words

Behaviour:
- Clocking and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: out_valid=0, y0=0, y1=0, out_zero=0, out_multi=0, err_cnt=0. Buffer empties, so in_ready=1 on the first cycle after reset.
- Reset mid-operation: rst wins over any simultaneous push or pop. Buffered entries are discarded and no handshake is honoured on a reset cycle.
- Handshakes:
  - Push when in_valid && in_ready at a rising edge.
  - Pop when out_valid && out_ready at a rising edge.
- Encoding (priority, highest index wins), with {y0,y1} = index of highest set bit:
  - d3 set -> 2'b11
  - else d2 -> 2'b10
  - else d1 -> 2'b01
  - else d0 -> 2'b00
  - d == 0 -> {y0,y1} = 2'b00, zero flag = 1.
- Multi flag: set when popcount(d) >= 2, e.g. d=4'b1010 -> {y0,y1}=2'b11, multi=1.
- Each buffer entry holds {y0,y1,zero,multi}, 4 bits. The encode is performed combinationally on d at push time and stored.
- Occupancy state machine:
  - EMPTY (0 entries): in_ready=1, out_valid=0. Push -> ONE.
  - ONE: in_ready=1, out_valid=1.
    - push only -> TWO
    - pop only -> EMPTY
    - push+pop -> ONE; the head is replaced by the new entry.
  - TWO: in_ready=0, out_valid=1. Pop -> ONE, and the second entry becomes the head in the same edge.
- in_ready depends on occupancy only, never on out_ready (no combinational ready path).
- Latency:
  - A word pushed into EMPTY appears at the outputs the next cycle.
  - Full throughput: one word per cycle while out_ready=1.
- Ordering is strict FIFO. The outputs y0/y1/out_zero/out_multi hold the head entry stably while out_valid=1 and out_ready=0.
- When out_valid=0, the outputs hold their last value. They do not return to 0; only rst clears them.
- err_cnt:
  - Increments by 1 on each push whose word is zero or multi-hot.
  - Saturates at all-ones with no wrap.
  - Not affected by pops.

Optional Feature:
Macro ENC_ONEHOT_CHECK_EN.
- Defined:
  - out_multi is computed and stored as above.
  - err_cnt counts zero and multi-hot pushes with saturation.
- Undefined:
  - Multi-hot detection and the counter logic are not compiled; out_multi is tied 0 and err_cnt is tied 0.
  - out_zero and the priority encode are unchanged.
- The port list is identical in both builds.

Test Plan:
1. Reset then single pushes: after rst for 2 cycles, push d=4'b0001, 0010, 0100, 1000 with out_ready=1. Outputs appear 1 cycle after each push as {y0,y1}=00, 01, 10, 11, with out_zero=0 and out_multi=0; err_cnt stays 0.
2. Backpressure/full: out_ready=0, push 4'b0100 then 4'b1000. in_ready drops to 0 after the second push and a third word 4'b0001 is not accepted. Raise out_ready: outputs are 10 then 11, then in_ready=1.
3. Simultaneous push+pop in ONE: hold occupancy at 1, push 4'b0010 in the same cycle the head (code 11) pops. Occupancy stays 1 and the next head is 01.
4. Zero/multi words (macro defined): push 4'b0000 and then 4'b0110.
   - 4'b0000 -> {y0,y1}=00, out_zero=1.
   - 4'b0110 -> {y0,y1}=10, out_multi=1.
   - err_cnt=2.
   - With ERR_CNT_W=2, push 5 bad words -> err_cnt=3 (saturated).
5. Macro undefined: repeat scenario 4. out_multi=0 and err_cnt=0 throughout; codes and out_zero are identical to the defined build.
6. Reset mid-operation: fill to TWO, then assert rst for 1 cycle together with in_valid=1 and out_ready=1. Next cycle out_valid=0, in_ready=1, err_cnt=0 and no entry is popped.
